// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller.
// Tracks a bubble (dirty) bit per stage, turns stall / flush / counted
// multi-cycle extend requests into per-stage hold strobes, and runs a
// RUN -> DRAIN -> HALTED state machine that stops fetch and empties the pipe.
// Stage 0 is fetch (youngest); stage STAGES-1 is writeback (oldest).
module pipe_ctrl #(
    parameter int STAGES = 5,
    parameter int EXT_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    input  logic [STAGES-1:0]         ext_start,
    input  logic [STAGES*EXT_W-1:0]   ext_len,
    input  logic                      halt_req,
    input  logic                      resume,
    output logic [STAGES-1:0]         keep,
    output logic [STAGES-1:0]         dirty,
    output logic [STAGES-1:0]         ext_busy,
    output logic                      fetch_en,
    output logic                      halted
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t              state_reg;
    logic                halted_reg;
    logic [STAGES-1:0]   dirty_reg;
    logic [STAGES-1:0]   dirty_next;
    logic [EXT_W-1:0]    cnt_reg  [STAGES];
    logic [EXT_W-1:0]    cnt_next [STAGES];

    logic [STAGES-1:0]   cnt_nz;
    logic [STAGES-1:0]   start_v;
    logic [STAGES-1:0]   block;
    logic [STAGES-1:0]   hold;
    logic [STAGES-1:0]   kill;
    logic                drained;

    // Per-stage request qualification, blocking and extend counter update
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [EXT_W-1:0] len;

        assign len         = ext_len[gi*EXT_W +: EXT_W];
        assign cnt_nz[gi]  = |cnt_reg[gi];
        // A new extend is accepted only on a valid, idle stage with a real length
        assign start_v[gi] = ext_start[gi] & (|len) & ~dirty_reg[gi] & ~cnt_nz[gi];
        assign block[gi]   = stall[gi] | cnt_nz[gi] | start_v[gi];

        // Kill wins over a fresh start; the start cycle itself counts as
        // the first blocked cycle, hence len-1.
        assign cnt_next[gi] = kill[gi]    ? '0 :
                              start_v[gi] ? len - EXT_W'(1) :
                              cnt_nz[gi]  ? cnt_reg[gi] - EXT_W'(1) :
                                            cnt_reg[gi];
    end

    // Hold and kill propagate from older (higher index) to younger stages
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_chain
        if (gi == STAGES - 1) begin : g_oldest
            assign hold[gi] = block[gi];
            assign kill[gi] = flush[gi];
        end else begin : g_younger
            assign hold[gi] = block[gi] | hold[gi+1];
            assign kill[gi] = flush[gi] | kill[gi+1];
        end
    end

    // Bubble tracking: held stages keep their bit (and absorb a flush);
    // advancing stages inherit from the predecessor, which injects a bubble
    // when the predecessor is held or squashed.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_dirty
        if (gi == 0) begin : g_fetch
            assign dirty_next[gi] = hold[gi] ? (dirty_reg[gi] | kill[gi])
                                             : ((state_reg != RUN) | kill[gi]);
        end else begin : g_body
            assign dirty_next[gi] = hold[gi] ? (dirty_reg[gi] | kill[gi])
                                             : (dirty_reg[gi-1] | hold[gi-1] | kill[gi-1]);
        end
    end

    // Pipeline is empty once every stage is a bubble and no extend is running
    assign drained = (&dirty_reg) & ~(|cnt_nz);

    // Stage bubble bits and extend counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            dirty_reg <= '1;
            for (int i = 0; i < STAGES; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            dirty_reg <= dirty_next;
            for (int i = 0; i < STAGES; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    // Drain / halt state machine with registered halted flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= RUN;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    // halt_req wins over a simultaneous resume here
                    if (halt_req) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_reg  <= HALTED;
                        halted_reg <= 1'b1;
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state_reg  <= RUN;
                        halted_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= RUN;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

    // Combinational strobes are forced quiet while reset is asserted
    assign keep     = rst ? hold : '0;
    assign fetch_en = rst & (state_reg == RUN) & ~hold[0];
    assign dirty    = dirty_reg;
    assign ext_busy = cnt_nz;
    assign halted   = halted_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed test of pipe_ctrl (STAGES=5, EXT_W=4).
// Linear sequence of directed steps with hand-computed expected values.
module tb_pipe_ctrl;

    localparam int STAGES = 5;
    localparam int EXT_W  = 4;

    logic                     clk;
    logic                     rst;
    logic [STAGES-1:0]        stall;
    logic [STAGES-1:0]        flush;
    logic [STAGES-1:0]        ext_start;
    logic [STAGES*EXT_W-1:0]  ext_len;
    logic                     halt_req;
    logic                     resume;
    logic [STAGES-1:0]        keep;
    logic [STAGES-1:0]        dirty;
    logic [STAGES-1:0]        ext_busy;
    logic                     fetch_en;
    logic                     halted;

    int n_assert;
    int n_fail;

    pipe_ctrl #(.STAGES(STAGES), .EXT_W(EXT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .ext_start (ext_start),
        .ext_len   (ext_len),
        .halt_req  (halt_req),
        .resume    (resume),
        .keep      (keep),
        .dirty     (dirty),
        .ext_busy  (ext_busy),
        .fetch_en  (fetch_en),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs[STAGES-1:0], exp[STAGES-1:0]);
        end
        $display("t=%0t chk %-14s obs=%b exp=%b", $time, tag, obs[STAGES-1:0], exp[STAGES-1:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [STAGES-1:0] exp_fill [5];
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        stall     = 5'b00100;
        flush     = '0;
        ext_start = '0;
        ext_len   = '0;
        halt_req  = 1'b0;
        resume    = 1'b0;

        // Reset values; strobes forced to 0 while rst is low
        tick();
        chk("rst_dirty", 32'(dirty), 32'(5'b11111));
        chk("rst_busy", 32'(ext_busy), 32'(5'b00000));
        chk("rst_halted", 32'(halted), 32'(1'b0));
        chk("rst_keep", 32'(keep), 32'(5'b00000));
        stall = '0;
        #1;
        chk("rst_fetch_en", 32'(fetch_en), 32'(1'b0));

        // Free run from reset: valid tokens shift in one stage per edge
        rst = 1'b1;
        exp_fill[0] = 5'b11110;
        exp_fill[1] = 5'b11100;
        exp_fill[2] = 5'b11000;
        exp_fill[3] = 5'b10000;
        exp_fill[4] = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fill_dirty", 32'(dirty), 32'(exp_fill[i]));
            chk("fill_keep", 32'(keep), 32'(5'b00000));
        end
        chk("run_fetch_en", 32'(fetch_en), 32'(1'b1));

        // One-cycle stall on stage 2
        stall = 5'b00100;
        #1;
        chk("stall_keep", 32'(keep), 32'(5'b00111));
        chk("stall_fetch", 32'(fetch_en), 32'(1'b0));
        tick();
        stall = '0;
        chk("stall_dirty", 32'(dirty), 32'(5'b01000));
        tick();
        chk("stall_dirty2", 32'(dirty), 32'(5'b10000));
        tick();
        chk("stall_dirty3", 32'(dirty), 32'(5'b00000));

        // Extend of 3 cycles on stage 3
        ext_len   = 20'h03000;
        ext_start = 5'b01000;
        #1;
        chk("ext_keep0", 32'(keep), 32'(5'b01111));
        chk("ext_busy0", 32'(ext_busy), 32'(5'b00000));
        tick();
        ext_start = '0;
        chk("ext_keep1", 32'(keep), 32'(5'b01111));
        chk("ext_busy1", 32'(ext_busy), 32'(5'b01000));
        chk("ext_dirty1", 32'(dirty), 32'(5'b10000));
        tick();
        chk("ext_keep2", 32'(keep), 32'(5'b01111));
        chk("ext_busy2", 32'(ext_busy), 32'(5'b01000));
        chk("ext_dirty2", 32'(dirty), 32'(5'b10000));
        tick();
        chk("ext_keep3", 32'(keep), 32'(5'b00000));
        chk("ext_busy3", 32'(ext_busy), 32'(5'b00000));
        chk("ext_dirty3", 32'(dirty), 32'(5'b10000));
        tick();
        chk("ext_dirty4", 32'(dirty), 32'(5'b00000));

        // Zero length extend is ignored
        ext_len   = '0;
        ext_start = 5'b01000;
        #1;
        chk("len0_keep", 32'(keep), 32'(5'b00000));
        tick();
        ext_start = '0;
        chk("len0_busy", 32'(ext_busy), 32'(5'b00000));
        chk("len0_dirty", 32'(dirty), 32'(5'b00000));

        // Flush stage 2 while stage 3 is stalled
        stall = 5'b01000;
        flush = 5'b00100;
        #1;
        chk("fs_keep", 32'(keep), 32'(5'b01111));
        tick();
        stall = '0;
        flush = '0;
        chk("fs_dirty", 32'(dirty), 32'(5'b10111));
        for (int i = 0; i < 5; i++) tick();
        chk("fs_refill", 32'(dirty), 32'(5'b00000));

        // Flush during an active extend clears the counter
        ext_len   = 20'h05000;
        ext_start = 5'b01000;
        tick();
        ext_start = '0;
        chk("fx_busy", 32'(ext_busy), 32'(5'b01000));
        flush = 5'b01000;
        #1;
        chk("fx_keep", 32'(keep), 32'(5'b01111));
        tick();
        flush = '0;
        chk("fx_busy_clr", 32'(ext_busy), 32'(5'b00000));
        chk("fx_dirty", 32'(dirty), 32'(5'b11111));
        chk("fx_keep_clr", 32'(keep), 32'(5'b00000));
        for (int i = 0; i < 5; i++) tick();
        chk("fx_refill", 32'(dirty), 32'(5'b00000));

        // Halt in a full pipe, with a simultaneous resume that must be ignored
        halt_req = 1'b1;
        resume   = 1'b1;
        #1;
        chk("halt_fetch0", 32'(fetch_en), 32'(1'b1));
        tick();
        halt_req = 1'b0;
        resume   = 1'b0;
        chk("halt_fetch1", 32'(fetch_en), 32'(1'b0));
        chk("halt_dirty0", 32'(dirty), 32'(5'b00000));
        exp_fill[0] = 5'b00001;
        exp_fill[1] = 5'b00011;
        exp_fill[2] = 5'b00111;
        exp_fill[3] = 5'b01111;
        exp_fill[4] = 5'b11111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("drain_dirty", 32'(dirty), 32'(exp_fill[i]));
            chk("drain_halted", 32'(halted), 32'(1'b0));
        end
        tick();
        chk("halted", 32'(halted), 32'(1'b1));
        chk("halted_fetch", 32'(fetch_en), 32'(1'b0));

        // Resume
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("res_halted", 32'(halted), 32'(1'b0));
        chk("res_dirty", 32'(dirty), 32'(5'b11111));
        chk("res_fetch", 32'(fetch_en), 32'(1'b1));
        tick();
        chk("res_dirty1", 32'(dirty), 32'(5'b11110));
        for (int i = 0; i < 4; i++) tick();
        chk("res_full", 32'(dirty), 32'(5'b00000));

        // Reset during DRAIN with an extend in flight on stage 4
        ext_len   = 20'h50000;
        ext_start = 5'b10000;
        halt_req  = 1'b1;
        tick();
        ext_start = '0;
        halt_req  = 1'b0;
        chk("md_busy", 32'(ext_busy), 32'(5'b10000));
        chk("md_fetch", 32'(fetch_en), 32'(1'b0));
        rst = 1'b0;
        #1;
        chk("md_keep_rst", 32'(keep), 32'(5'b00000));
        tick();
        chk("md_dirty", 32'(dirty), 32'(5'b11111));
        chk("md_busy_clr", 32'(ext_busy), 32'(5'b00000));
        chk("md_halted", 32'(halted), 32'(1'b0));
        rst = 1'b1;
        #1;
        chk("md_fetch_run", 32'(fetch_en), 32'(1'b1));
        tick();
        chk("md_dirty1", 32'(dirty), 32'(5'b11110));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
